div_unit: RTL

- Iterative radix-2 restoring divider for MIPS DIV/DIVU.
- Sits directly upstream of the HI/LO register pair in the execute stage.
- Accepts operands on a start pulse and runs one quotient bit per cycle.
- Presents the remainder on hi_o and the quotient on lo_o, with a one-cycle write_en pulse that drives the HI/LO write port.

---
 rtl/div_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle; the remainder goes to hi_o and the quotient to
// lo_o, with a single-cycle write_en pulse driving the HI/LO write port.
// Optional build macro: DIV_ZERO_FAST_EN. When it is defined, a zero divisor
// completes in one cycle and skips the iteration state.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             write_en,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] one_v;
        one_v = {{(WIDTH-1){1'b0}}, 1'b1};
        return neg ? (~v + one_v) : v;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   div_r;
    logic               sign_q_r;
    logic               sign_r_r;

    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   rem_nxt_s;
    logic [WIDTH-1:0]   quot_nxt_s;
    logic               neg_a_s;
    logic               neg_b_s;

    // One restoring step: shift {rem, quot} left, trial-subtract, keep or restore.
    always_comb begin
        shift_s = {rem_r, quot_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, div_r};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s  = trial_s[WIDTH-1:0];
            quot_nxt_s = {quot_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s  = shift_s[WIDTH-1:0];
            quot_nxt_s = {quot_r[WIDTH-2:0], 1'b0};
        end
    end

    // Operand signs at the start edge; unsigned ops are treated as positive.
    always_comb begin
        if (signed_op) begin
            neg_a_s = dividend[WIDTH-1];
            neg_b_s = divisor[WIDTH-1];
        end else begin
            neg_a_s = 1'b0;
            neg_b_s = 1'b0;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            count_r  <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quot_r   <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            busy     <= 1'b0;
            write_en <= 1'b0;
            hi_o     <= {WIDTH{1'b0}};
            lo_o     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    write_en <= 1'b0;
                    busy     <= 1'b0;
                    if (cancel) begin
                        state_r <= S_IDLE;
                    end else if (start) begin
                        rem_r    <= {WIDTH{1'b0}};
                        quot_r   <= neg_if(neg_a_s, dividend);
                        div_r    <= neg_if(neg_b_s, divisor);
                        sign_q_r <= neg_a_s ^ neg_b_s;
                        sign_r_r <= neg_a_s;
                        count_r  <= {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Quotient is all-ones magnitude; remainder equals dividend.
                            state_r  <= S_DONE;
                            write_en <= 1'b1;
                            hi_o     <= dividend;
                            lo_o     <= neg_a_s ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
                        end else begin
                            state_r <= S_DIV;
                            busy    <= 1'b1;
                        end
`else
                        state_r <= S_DIV;
                        busy    <= 1'b1;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        state_r  <= S_IDLE;
                        busy     <= 1'b0;
                        write_en <= 1'b0;
                    end else begin
                        rem_r  <= rem_nxt_s;
                        quot_r <= quot_nxt_s;
                        if (count_r == CNT_W'(WIDTH - 1)) begin
                            // Last iteration: apply sign fix-up straight into HI/LO.
                            state_r  <= S_DONE;
                            busy     <= 1'b0;
                            write_en <= 1'b1;
                            lo_o     <= neg_if(sign_q_r, quot_nxt_s);
                            hi_o     <= neg_if(sign_r_r, rem_nxt_s);
                        end else begin
                            count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            busy     <= 1'b1;
                            write_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    busy     <= 1'b0;
                    write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
